// File: rtl/fsic_serdes_link_ctrl_if.sv
// rtl/fsic_serdes_link_ctrl_if.sv - AXI-Lite config port between link controller and serdes
interface fsic_serdes_link_ctrl_if #(
  parameter int pADDR_WIDTH = 10,
  parameter int pDATA_WIDTH = 32
) ();
  logic                       axi_awvalid;
  logic [pADDR_WIDTH+1:2]     axi_awaddr;
  logic                       axi_awready;
  logic                       axi_wvalid;
  logic [pDATA_WIDTH-1:0]     axi_wdata;
  logic [(pDATA_WIDTH/8)-1:0] axi_wstrb;
  logic                       axi_wready;
  logic                       axi_arvalid;
  logic [pADDR_WIDTH+1:2]     axi_araddr;
  logic                       axi_arready;
  logic                       axi_rvalid;
  logic [pDATA_WIDTH-1:0]     axi_rdata;
  logic                       axi_rready;

  modport master (
    output axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb,
    output axi_arvalid, axi_araddr, axi_rready,
    input  axi_awready, axi_wready, axi_arready, axi_rvalid, axi_rdata
  );

  modport slave (
    input  axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb,
    input  axi_arvalid, axi_araddr, axi_rready,
    output axi_awready, axi_wready, axi_arready, axi_rvalid, axi_rdata
  );
endinterface

// File: rtl/fsic_serdes_link_ctrl.sv
// rtl/fsic_serdes_link_ctrl.sv - serdes link bring-up sequencer acting as AXI-Lite master
module fsic_serdes_link_ctrl #(
  parameter int pADDR_WIDTH = 10,
  parameter int pDATA_WIDTH = 32,
  parameter int pRX_SETTLE  = 16,
  parameter int pTX_SETTLE  = 16,
  parameter int pMAX_RETRY  = 3,
  parameter int pHS_TIMEOUT = 64
) (
  input  logic                              axi_clk,
  input  logic                              axi_reset,
  input  logic                              start,
  input  logic                              stop,
  output logic                              cc_ls_enable,
  output logic                              busy,
  output logic                              link_up,
  output logic                              fail,
  output logic [$clog2(pMAX_RETRY+1)-1:0]   retry_cnt,
  fsic_serdes_link_ctrl_if.master           bus
);

  localparam int RC_W    = $clog2(pMAX_RETRY + 1);
  localparam int STRB_W  = pDATA_WIDTH / 8;
  localparam int CNT_MAX = (pHS_TIMEOUT > pRX_SETTLE) ?
                           ((pHS_TIMEOUT > pTX_SETTLE) ? pHS_TIMEOUT : pTX_SETTLE) :
                           ((pRX_SETTLE > pTX_SETTLE) ? pRX_SETTLE : pTX_SETTLE);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(pRX_SETTLE - 1);
  localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(pTX_SETTLE - 1);
  localparam logic [CNT_W-1:0] HS_LAST   = CNT_W'(pHS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_TOP   = CNT_W'(CNT_MAX);
  localparam logic [RC_W-1:0]  RETRY_MAX = RC_W'(pMAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_RX, S_WAIT_RX, S_WR_TX, S_WAIT_TX,
    S_RD_AR, S_RD_R, S_CHECK, S_UP, S_WR_OFF, S_FAIL
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [RC_W-1:0]          retry_q, retry_d;
  logic [1:0]               rb_q, rb_d;

  logic                     wvalid_q, arvalid_q, rready_q;
  logic [pDATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]        wstrb_q;
  logic                     cc_q, busy_q, link_q, fail_q;

  logic                     wr_done, hs_to;
  logic                     is_wr_d;
  logic [pDATA_WIDTH-1:0]   wdata_d;
  logic                     unused_rdata;

  assign wr_done = bus.axi_awready && bus.axi_wready;
  assign hs_to   = (cnt_q == HS_LAST);
  assign unused_rdata = ^bus.axi_rdata[pDATA_WIDTH-1:2];

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    rb_d    = rb_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          retry_d = '0;
          state_d = S_WR_RX;
        end
      end
      S_WR_RX: begin
        if (wr_done)    state_d = S_WAIT_RX;
        else if (hs_to) begin state_d = S_CHECK; rb_d = 2'b00; end
      end
      S_WAIT_RX: if (cnt_q == RX_LAST) state_d = S_WR_TX;
      S_WR_TX: begin
        if (wr_done)    state_d = S_WAIT_TX;
        else if (hs_to) begin state_d = S_CHECK; rb_d = 2'b00; end
      end
      S_WAIT_TX: if (cnt_q == TX_LAST) state_d = S_RD_AR;
      S_RD_AR: begin
        if (bus.axi_arready) state_d = S_RD_R;
        else if (hs_to)      begin state_d = S_CHECK; rb_d = 2'b00; end
      end
      S_RD_R: begin
        if (bus.axi_rvalid) begin
          rb_d    = bus.axi_rdata[1:0];
          state_d = S_CHECK;
        end else if (hs_to) begin
          state_d = S_CHECK;
          rb_d    = 2'b00;
        end
      end
      S_CHECK: begin
        if (rb_q == 2'b11) begin
          state_d = S_UP;
        end else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + RC_W'(1);
          state_d = S_WR_RX;
        end else begin
          state_d = S_FAIL;
        end
      end
      S_UP: if (stop) state_d = S_WR_OFF;
      // A link-down write that never completes leaves the serdes state unknown.
      S_WR_OFF: begin
        if (wr_done)    state_d = S_IDLE;
        else if (hs_to) state_d = S_FAIL;
      end
      S_FAIL: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          retry_d = '0;
          state_d = S_WR_RX;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Settle and handshake timing share one counter that restarts on every state change.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != CNT_TOP) cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    is_wr_d = (state_d == S_WR_RX) || (state_d == S_WR_TX) || (state_d == S_WR_OFF);
    wdata_d = '0;
    case (state_d)
      S_WR_RX: wdata_d = pDATA_WIDTH'(1);
      S_WR_TX: wdata_d = pDATA_WIDTH'(3);
      default: wdata_d = '0;
    endcase
  end

  // Outputs are registered from the next state so they stay Moore with the state register.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      retry_q   <= '0;
      rb_q      <= 2'b00;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      cc_q      <= 1'b0;
      busy_q    <= 1'b0;
      link_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      rb_q      <= rb_d;
      wvalid_q  <= is_wr_d;
      arvalid_q <= (state_d == S_RD_AR);
      rready_q  <= (state_d == S_RD_R);
      wdata_q   <= wdata_d;
      wstrb_q   <= is_wr_d ? STRB_W'(1) : '0;
      cc_q      <= is_wr_d || (state_d == S_RD_AR) || (state_d == S_RD_R);
      busy_q    <= !((state_d == S_IDLE) || (state_d == S_UP) || (state_d == S_FAIL));
      link_q    <= (state_d == S_UP);
      fail_q    <= (state_d == S_FAIL);
    end
  end

  assign bus.axi_awvalid = wvalid_q;
  assign bus.axi_wvalid  = wvalid_q;
  assign bus.axi_awaddr  = '0;
  assign bus.axi_wdata   = wdata_q;
  assign bus.axi_wstrb   = wstrb_q;
  assign bus.axi_arvalid = arvalid_q;
  assign bus.axi_araddr  = '0;
  assign bus.axi_rready  = rready_q;

  assign cc_ls_enable = cc_q;
  assign busy         = busy_q;
  assign link_up      = link_q;
  assign fail         = fail_q;
  assign retry_cnt    = retry_q;

endmodule

// File: tb/tb_fsic_serdes_link_ctrl.sv
// tb/tb_fsic_serdes_link_ctrl.sv - directed bench for fsic_serdes_link_ctrl with an ideal serdes model
module tb_fsic_serdes_link_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic cc_ls_enable, busy, link_up, fail;
  logic [1:0] retry_cnt;

  fsic_serdes_link_ctrl_if #(.pADDR_WIDTH(10), .pDATA_WIDTH(32)) bus ();

  fsic_serdes_link_ctrl dut (
    .axi_clk      (clk),
    .axi_reset    (rst),
    .start        (start),
    .stop         (stop),
    .cc_ls_enable (cc_ls_enable),
    .busy         (busy),
    .link_up      (link_up),
    .fail         (fail),
    .retry_cnt    (retry_cnt),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // serdes model: enable register, configurable read latency, optional bad readback
  logic [1:0] ctl = 2'b00;
  logic       bad = 1'b0;
  int         rdelay = 0;
  logic       rd_pend = 1'b0;
  int         rd_wait = 0;
  int         wr_cyc[$];
  logic [31:0] wr_dat[$];
  logic [3:0] wr_stb[$];
  int         ar_cnt = 0;
  int         ar_cyc = -1;
  int         r_cyc = -1;
  int         rwait_cnt = 0;

  assign bus.axi_rvalid = rd_pend && (rd_wait == 0);
  assign bus.axi_rdata  = {30'b0, (bad ? 2'b01 : ctl)};

  wire [7:0] outs = {bus.axi_awvalid, bus.axi_wvalid, bus.axi_arvalid, bus.axi_rready,
                     cc_ls_enable, busy, link_up, fail};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.axi_awvalid && bus.axi_wvalid && bus.axi_awready && bus.axi_wready) begin
      wr_cyc.push_back(cyc);
      wr_dat.push_back(bus.axi_wdata);
      wr_stb.push_back(bus.axi_wstrb);
      ctl <= bus.axi_wdata[1:0];
    end
    if (bus.axi_rready && !bus.axi_rvalid) rwait_cnt <= rwait_cnt + 1;
    if (rst) begin
      rd_pend <= 1'b0;
      rd_wait <= 0;
    end else if (bus.axi_arvalid && bus.axi_arready) begin
      rd_pend <= 1'b1;
      rd_wait <= rdelay;
      ar_cnt  <= ar_cnt + 1;
      ar_cyc  <= cyc;
    end else if (rd_pend && rd_wait != 0) begin
      rd_wait <= rd_wait - 1;
    end else if (bus.axi_rvalid && bus.axi_rready) begin
      rd_pend <= 1'b0;
      r_cyc   <= cyc;
    end
  end

  task automatic pulse_start(output int off);
    @(negedge clk);
    off = cyc;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_for(input int which, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((which == 0 && link_up) || (which == 1 && fail)) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== 8'h00 || retry_cnt !== 2'd0) begin
      failures++;
      $display("FAIL reset_outs: outs=%b retry=%0d expected outs=00000000 retry=0", outs, retry_cnt);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== 8'h00) begin
      failures++;
      $display("FAIL reset_idle: outs=%b expected 00000000", outs);
    end
  endtask

  task automatic test_nominal(input string tag);
    int off, at, n0;
    n0 = wr_cyc.size();
    pulse_start(off);
    @(negedge clk);
    checks++;
    if (outs !== 8'b1100_1100 || bus.axi_wdata !== 32'h1 || bus.axi_wstrb !== 4'h1) begin
      failures++;
      $display("FAIL %s_cycle1: outs=%b wdata=%h wstrb=%h expected outs=11001100 wdata=1 wstrb=1",
               tag, outs, bus.axi_wdata, bus.axi_wstrb);
    end
    wait_for(0, 200, at);
    checks++;
    if (at - off !== 38) begin
      failures++;
      $display("FAIL %s_link_cycle: got %0d expected 38", tag, at - off);
    end
    checks++;
    if (wr_cyc.size() - n0 !== 2) begin
      failures++;
      $display("FAIL %s_write_count: got %0d expected 2", tag, wr_cyc.size() - n0);
    end else begin
      checks++;
      if (wr_cyc[n0] - off !== 1 || wr_dat[n0] !== 32'h1 || wr_cyc[n0+1] - off !== 18 ||
          wr_dat[n0+1] !== 32'h3 || wr_stb[n0+1] !== 4'h1) begin
        failures++;
        $display("FAIL %s_writes: c0=%0d d0=%h c1=%0d d1=%h s1=%h expected c0=1 d0=1 c1=18 d1=3 s1=1",
                 tag, wr_cyc[n0] - off, wr_dat[n0], wr_cyc[n0+1] - off, wr_dat[n0+1], wr_stb[n0+1]);
      end
    end
    checks++;
    if (ar_cyc - off !== 35 || r_cyc - off !== 36) begin
      failures++;
      $display("FAIL %s_read_cycles: ar=%0d r=%0d expected ar=35 r=36", tag, ar_cyc - off, r_cyc - off);
    end
    checks++;
    if (outs !== 8'b0000_0010 || retry_cnt !== 2'd0) begin
      failures++;
      $display("FAIL %s_up_state: outs=%b retry=%0d expected outs=00000010 retry=0", tag, outs, retry_cnt);
    end
  endtask

  task automatic test_link_down();
    int off, n0;
    n0 = wr_cyc.size();
    @(negedge clk);
    off = cyc;
    stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_cyc.size() - n0 !== 1) begin
      failures++;
      $display("FAIL linkdown_write_count: got %0d expected 1", wr_cyc.size() - n0);
    end else begin
      checks++;
      if (wr_cyc[n0] - off !== 1 || wr_dat[n0] !== 32'h0 || wr_stb[n0] !== 4'h1) begin
        failures++;
        $display("FAIL linkdown_write: cyc=%0d data=%h strb=%h expected cyc=1 data=0 strb=1",
                 wr_cyc[n0] - off, wr_dat[n0], wr_stb[n0]);
      end
    end
    checks++;
    if (outs !== 8'h00) begin
      failures++;
      $display("FAIL linkdown_idle: outs=%b expected 00000000", outs);
    end
  endtask

  task automatic test_wready_stall();
    int off, at, held, n0;
    n0 = wr_cyc.size();
    held = 0;
    bus.axi_wready = 1'b0;
    pulse_start(off);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.axi_awvalid) held++;
      else if (held > 0) break;
    end
    bus.axi_wready = 1'b1;
    checks++;
    if (held !== 64) begin
      failures++;
      $display("FAIL stall_valid_hold: got %0d expected 64", held);
    end
    wait_for(0, 300, at);
    checks++;
    if (at - off !== 103 || retry_cnt !== 2'd1) begin
      failures++;
      $display("FAIL stall_retry_up: link=%0d retry=%0d expected link=103 retry=1", at - off, retry_cnt);
    end
    checks++;
    if (wr_cyc.size() - n0 !== 2 || wr_cyc[n0] - off !== 66) begin
      failures++;
      $display("FAIL stall_first_write: count=%0d expected count=2 first at cycle 66", wr_cyc.size() - n0);
    end
  endtask

  task automatic test_rvalid_delay();
    int off, at, w0;
    rdelay = 5;
    w0 = rwait_cnt;
    pulse_start(off);
    wait_for(0, 200, at);
    rdelay = 0;
    checks++;
    if (at - off !== 43) begin
      failures++;
      $display("FAIL rdelay_link_cycle: got %0d expected 43", at - off);
    end
    checks++;
    if (rwait_cnt - w0 !== 5 || r_cyc - off !== 41) begin
      failures++;
      $display("FAIL rdelay_rready_wait: wait=%0d r=%0d expected wait=5 r=41", rwait_cnt - w0, r_cyc - off);
    end
  endtask

  task automatic test_bad_readback();
    int off, at, n0, a0;
    n0 = wr_cyc.size();
    a0 = ar_cnt;
    bad = 1'b1;
    pulse_start(off);
    wait_for(1, 400, at);
    checks++;
    if (at - off !== 149) begin
      failures++;
      $display("FAIL bad_fail_cycle: got %0d expected 149", at - off);
    end
    checks++;
    if (wr_cyc.size() - n0 !== 8 || ar_cnt - a0 !== 4) begin
      failures++;
      $display("FAIL bad_attempts: writes=%0d reads=%0d expected writes=8 reads=4", wr_cyc.size() - n0, ar_cnt - a0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== 8'b0000_0001 || retry_cnt !== 2'd3) begin
      failures++;
      $display("FAIL bad_fail_state: outs=%b retry=%0d expected outs=00000001 retry=3", outs, retry_cnt);
    end
    bad = 1'b0;
  endtask

  task automatic test_fail_start_stop();
    int n0;
    n0 = wr_cyc.size();
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (outs !== 8'h00 || wr_cyc.size() - n0 !== 0) begin
      failures++;
      $display("FAIL fail_startstop_idle: outs=%b writes=%0d expected outs=00000000 writes=0", outs, wr_cyc.size() - n0);
    end
  endtask

  task automatic test_reset_mid();
    int off, n0;
    n0 = wr_cyc.size();
    pulse_start(off);
    while (cyc < off + 25) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 8'h00 || retry_cnt !== 2'd0) begin
      failures++;
      $display("FAIL midreset_outs: outs=%b retry=%0d expected outs=00000000 retry=0", outs, retry_cnt);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (wr_cyc.size() - n0 !== 2 || outs !== 8'h00) begin
      failures++;
      $display("FAIL midreset_quiet: writes=%0d outs=%b expected writes=2 outs=00000000", wr_cyc.size() - n0, outs);
    end
    test_nominal("restart");
  endtask

  initial begin
    bus.axi_awready = 1'b1;
    bus.axi_wready  = 1'b1;
    bus.axi_arready = 1'b1;
    test_reset();
    test_nominal("nominal");
    test_link_down();
    test_wready_stall();
    test_link_down();
    test_rvalid_delay();
    test_link_down();
    test_bad_readback();
    test_fail_start_stop();
    test_reset_mid();
    test_link_down();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
